rtc_picoblaze_controller: RTL and testbench



---
 rtl/rtc_picoblaze_controller.sv | 264 ++++++++++++++++++++++++++
 tb/tb_rtc_picoblaze_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rtc_picoblaze_controller.sv
// Port-write sequencer for a multiplexed-bus RTC. All register updates go
// through the exposed out_port/port_id/write_strobe bus into a port-mapped
// register bank. The FSM handles button edits, periodic read sweeps, the
// commit of the edited fields and the timer-enable write.
module rtc_picoblaze_controller #(
   parameter int TPH       = 10,
   parameter int RD_PERIOD = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       BTNPi,
   input  logic       BTNUi,
   input  logic       BTNDi,
   input  logic       BTNRi,
   input  logic       BTNLi,
   input  logic       BTNFi,
   input  logic       BTNTi,
   output logic       AD,
   output logic       CS,
   output logic       RD,
   output logic       WR,
   output logic [7:0] out_port,
   output logic [7:0] port_id,
   output logic       write_strobe,
   output logic       k_write_strobe,
   output logic [7:0] anno_vga_port,
   output logic [7:0] mes_vga_port,
   output logic [7:0] dia_vga_port,
   output logic [7:0] rhora_vga_port,
   output logic [7:0] rmin_vga_port,
   output logic [7:0] rseg_vga_port,
   output logic [7:0] thora_vga_port,
   output logic [7:0] tmin_vga_port,
   output logic [7:0] tseg_vga_port,
   output logic [7:0] addressin_rtc_port,
   output logic [7:0] datain_rtc_port,
   output logic [7:0] win_port,
   output logic [7:0] rin_port,
   output logic [7:0] control_port,
   output logic [7:0] programando_port,
   output logic [7:0] donew_port,
   output logic [7:0] doner_port
);

   typedef enum logic [3:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA, S_FLAG, S_DONE0,
                             S_BUS, S_CLR, S_DONE1, S_EXIT} state_t;
   typedef enum logic [1:0] {K_SWEEP, K_COMMIT, K_TIMER} kind_t;

   localparam logic [15:0] BUS_LAST = 16'(2*TPH+2);

   state_t      state_q, state_d;
   kind_t       kind_q, kind_d;
   logic [3:0]  tx_idx_q, tx_idx_d;
   logic [3:0]  field_q, field_d;
   logic [15:0] bus_cnt_q, bus_cnt_d;
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [6:0]  sync1_q, sync2_q, prev_q;
   logic [7:0]  out_port_q, out_port_d, port_id_q, port_id_d;
   logic        ws_q, ws_d, kws_q, kws_d;
   logic [7:0]  bank_q [17];
   logic [6:0]  rise;
   logic        prog, is_wr, last_tx;
   logic [7:0]  fld_cur, tx_addr, tx_data;

   // BCD field limits, indexed by field number (anno, mes, dia, rh, rm, rs, th, tm, ts)
   function automatic logic [7:0] fld_max(input logic [3:0] f);
      case (f)
         4'd0:       return 8'h99;
         4'd1:       return 8'h12;
         4'd2:       return 8'h31;
         4'd3, 4'd6: return 8'h23;
         default:    return 8'h59;
      endcase
   endfunction

   function automatic logic [7:0] fld_min(input logic [3:0] f);
      return (f == 4'd1 || f == 4'd2) ? 8'h01 : 8'h00;
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mn,
                                          input logic [7:0] mx);
      if (v >= mx || v < mn) return mn;
      if (v[3:0] >= 4'd9)    return {v[7:4] + 4'd1, 4'd0};
      return v + 8'd1;
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mn,
                                          input logic [7:0] mx);
      if (v <= mn || v > mx) return mx;
      if (v[3:0] == 4'd0)    return {v[7:4] - 4'd1, 4'd9};
      return v - 8'd1;
   endfunction

   assign rise    = sync2_q & ~prev_q;
   assign prog    = bank_q[14][0];
   assign is_wr   = (kind_q != K_SWEEP);
   assign last_tx = (kind_q == K_TIMER) || (kind_q == K_SWEEP && tx_idx_q == 4'd8) ||
                    (kind_q == K_COMMIT && tx_idx_q == 4'd9);

   // Select the edited field value and the address/data of the current transaction
   always_comb begin
      fld_cur = 8'h00;
      for (int i = 0; i < 9; i++)
         if (field_q == 4'(i)) fld_cur = bank_q[i];
      tx_addr = 8'hF0;
      tx_data = 8'hF0;
      case (tx_idx_q)
         4'd0: begin tx_addr = 8'h21; tx_data = bank_q[5]; end
         4'd1: begin tx_addr = 8'h22; tx_data = bank_q[4]; end
         4'd2: begin tx_addr = 8'h23; tx_data = bank_q[3]; end
         4'd3: begin tx_addr = 8'h24; tx_data = bank_q[2]; end
         4'd4: begin tx_addr = 8'h25; tx_data = bank_q[1]; end
         4'd5: begin tx_addr = 8'h26; tx_data = bank_q[0]; end
         4'd6: begin tx_addr = 8'h41; tx_data = bank_q[8]; end
         4'd7: begin tx_addr = 8'h42; tx_data = bank_q[7]; end
         4'd8: begin tx_addr = 8'h43; tx_data = bank_q[6]; end
         default: ;
      endcase
      if (kind_q == K_TIMER) begin
         tx_addr = 8'h00;
         tx_data = bank_q[13];
      end
   end

   // Next-state logic: button dispatch, sweep timer and the per-transaction port-write sequence
   always_comb begin
      state_d   = state_q;
      kind_d    = kind_q;
      tx_idx_d  = tx_idx_q;
      field_d   = field_q;
      bus_cnt_d = bus_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      out_port_d = out_port_q;
      port_id_d  = port_id_q;
      ws_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            rd_cnt_d = prog ? 32'd0 : rd_cnt_q + 32'd1;
            if (rise[6]) begin
               ws_d = 1'b1; port_id_d = 8'h0F; out_port_d = prog ? 8'h00 : 8'h01;
               if (!prog) field_d = 4'd0;
               state_d = S_WAIT;
            end else if (rise[5] && prog) begin
               kind_d = K_COMMIT; tx_idx_d = 4'd0; state_d = S_ADDR;
            end else if (rise[4]) begin
               ws_d = 1'b1; port_id_d = 8'h0E; out_port_d = {7'd0, ~bank_q[13][0]};
               kind_d = K_TIMER; tx_idx_d = 4'd0; state_d = S_ADDR;
            end else if (rise[3] && prog) begin
               field_d = (field_q == 4'd8) ? 4'd0 : field_q + 4'd1;
            end else if (rise[2] && prog) begin
               field_d = (field_q == 4'd0) ? 4'd8 : field_q - 4'd1;
            end else if ((rise[1] || rise[0]) && prog) begin
               ws_d = 1'b1; port_id_d = {4'd0, field_q} + 8'd1;
               out_port_d = rise[1] ? bcd_inc(fld_cur, fld_min(field_q), fld_max(field_q))
                                    : bcd_dec(fld_cur, fld_min(field_q), fld_max(field_q));
               state_d = S_WAIT;
            end else if (!prog && rd_cnt_q >= 32'(RD_PERIOD-1)) begin
               kind_d = K_SWEEP; tx_idx_d = 4'd0; rd_cnt_d = 32'd0; state_d = S_ADDR;
            end
         end
         S_WAIT:  state_d = S_IDLE;
         S_ADDR: begin
            ws_d = 1'b1; port_id_d = 8'h0A; out_port_d = tx_addr;
            state_d = is_wr ? S_DATA : S_FLAG;
         end
         S_DATA: begin
            ws_d = 1'b1; port_id_d = 8'h0B; out_port_d = tx_data; state_d = S_FLAG;
         end
         S_FLAG: begin
            ws_d = 1'b1; port_id_d = is_wr ? 8'h0C : 8'h0D; out_port_d = 8'h01;
            state_d = S_DONE0;
         end
         S_DONE0: begin
            ws_d = 1'b1; port_id_d = is_wr ? 8'h10 : 8'h11; out_port_d = 8'h00;
            bus_cnt_d = 16'd0; state_d = S_BUS;
         end
         S_BUS: begin
            if (bus_cnt_q == BUS_LAST) state_d = S_CLR;
            else bus_cnt_d = bus_cnt_q + 16'd1;
         end
         S_CLR: begin
            ws_d = 1'b1; port_id_d = is_wr ? 8'h0C : 8'h0D; out_port_d = 8'h00;
            state_d = S_DONE1;
         end
         S_DONE1: begin
            ws_d = 1'b1; port_id_d = is_wr ? 8'h10 : 8'h11; out_port_d = 8'h01;
            if (!last_tx) begin
               tx_idx_d = tx_idx_q + 4'd1; state_d = S_ADDR;
            end else begin
               state_d = (kind_q == K_COMMIT) ? S_EXIT : S_WAIT;
            end
         end
         S_EXIT: begin
            ws_d = 1'b1; port_id_d = 8'h0F; out_port_d = 8'h00; state_d = S_WAIT;
         end
         default: state_d = S_IDLE;
      endcase
      kws_d = ws_d && (port_id_d == 8'h0E);
   end

   // RTC bus strobes decoded from the bus-phase counter
   always_comb begin
      CS = 1'b1; AD = 1'b1; RD = 1'b1; WR = 1'b1;
      if (state_q == S_BUS) begin
         CS = 1'b0;
         if (bus_cnt_q <= 16'(TPH+1)) begin
            AD = 1'b0;
            if (bus_cnt_q >= 16'd1 && bus_cnt_q <= 16'(TPH)) WR = 1'b0;
         end else if (bus_cnt_q <= 16'(2*TPH+1)) begin
            if (is_wr) WR = 1'b0;
            else       RD = 1'b0;
         end
      end
   end

   // Sequencer state, button synchronizers and the port-write bus registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;   kind_q <= K_SWEEP;  tx_idx_q <= 4'd0;  field_q <= 4'd0;
         bus_cnt_q <= 16'd0;  rd_cnt_q <= 32'd0;
         sync1_q <= 7'd0;     sync2_q <= 7'd0;    prev_q <= 7'd0;
         out_port_q <= 8'h00; port_id_q <= 8'h00; ws_q <= 1'b0;      kws_q <= 1'b0;
      end else begin
         state_q <= state_d;  kind_q <= kind_d;   tx_idx_q <= tx_idx_d; field_q <= field_d;
         bus_cnt_q <= bus_cnt_d; rd_cnt_q <= rd_cnt_d;
         sync1_q <= {BTNPi, BTNFi, BTNTi, BTNRi, BTNLi, BTNUi, BTNDi};
         sync2_q <= sync1_q;  prev_q <= sync2_q;
         out_port_q <= out_port_d; port_id_q <= port_id_d; ws_q <= ws_d; kws_q <= kws_d;
      end
   end

   // Port-mapped register bank: entry i answers to port_id i+1
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 17; i++) bank_q[i] <= 8'h00;
      end else if (ws_q) begin
         for (int i = 0; i < 17; i++)
            if (port_id_q == 8'(i+1)) bank_q[i] <= out_port_q;
      end
   end

   assign out_port       = out_port_q;
   assign port_id        = port_id_q;
   assign write_strobe   = ws_q;
   assign k_write_strobe = kws_q;
   assign anno_vga_port  = bank_q[0];
   assign mes_vga_port   = bank_q[1];
   assign dia_vga_port   = bank_q[2];
   assign rhora_vga_port = bank_q[3];
   assign rmin_vga_port  = bank_q[4];
   assign rseg_vga_port  = bank_q[5];
   assign thora_vga_port = bank_q[6];
   assign tmin_vga_port  = bank_q[7];
   assign tseg_vga_port  = bank_q[8];
   assign addressin_rtc_port = bank_q[9];
   assign datain_rtc_port    = bank_q[10];
   assign win_port           = bank_q[11];
   assign rin_port           = bank_q[12];
   assign control_port       = bank_q[13];
   assign programando_port   = bank_q[14];
   assign donew_port         = bank_q[15];
   assign doner_port         = bank_q[16];

endmodule

// File: tb/tb_rtc_picoblaze_controller.sv
// Directed bench for rtc_picoblaze_controller: reset state, read sweep,
// field editing with wrap-around, commit, timer toggle and mid-bus reset.
module tb_rtc_picoblaze_controller;

   localparam int TPH = 3;
   localparam int RDP = 300;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic BTNPi = 0, BTNUi = 0, BTNDi = 0, BTNRi = 0, BTNLi = 0, BTNFi = 0, BTNTi = 0;
   logic AD, CS, RD, WR, write_strobe, k_write_strobe;
   logic [7:0] out_port, port_id;
   // 0 anno,1 mes,2 dia,3 rhora,4 rmin,5 rseg,6 thora,7 tmin,8 tseg,
   // 9 addrin,10 datain,11 win,12 rin,13 control,14 prog,15 donew,16 doner
   logic [7:0] regs [17];

   int n_total = 0, n_pass = 0, n_fail = 0;
   int n, cs_len, rd_len, wr_len, ws_cnt;

   logic [7:0] sweep_addr [9]  = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
   logic [7:0] cmt_addr   [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43, 8'hF0};
   logic [7:0] cmt_data   [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h03, 8'h59, 8'h00, 8'h00, 8'hF0};

   rtc_picoblaze_controller #(.TPH(TPH), .RD_PERIOD(RDP)) dut (
      .clock(clock), .reset(reset),
      .BTNPi(BTNPi), .BTNUi(BTNUi), .BTNDi(BTNDi), .BTNRi(BTNRi),
      .BTNLi(BTNLi), .BTNFi(BTNFi), .BTNTi(BTNTi),
      .AD(AD), .CS(CS), .RD(RD), .WR(WR),
      .out_port(out_port), .port_id(port_id),
      .write_strobe(write_strobe), .k_write_strobe(k_write_strobe),
      .anno_vga_port(regs[0]), .mes_vga_port(regs[1]), .dia_vga_port(regs[2]),
      .rhora_vga_port(regs[3]), .rmin_vga_port(regs[4]), .rseg_vga_port(regs[5]),
      .thora_vga_port(regs[6]), .tmin_vga_port(regs[7]), .tseg_vga_port(regs[8]),
      .addressin_rtc_port(regs[9]), .datain_rtc_port(regs[10]),
      .win_port(regs[11]), .rin_port(regs[12]), .control_port(regs[13]),
      .programando_port(regs[14]), .donew_port(regs[15]), .doner_port(regs[16])
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // 0=P 1=U 2=D 3=R 4=L 5=F 6=T
   task automatic press(input int b);
      @(negedge clock);
      case (b)
         0: BTNPi = 1'b1;
         1: BTNUi = 1'b1;
         2: BTNDi = 1'b1;
         3: BTNRi = 1'b1;
         4: BTNLi = 1'b1;
         5: BTNFi = 1'b1;
         default: BTNTi = 1'b1;
      endcase
      repeat (2) @(negedge clock);
      BTNPi = 0; BTNUi = 0; BTNDi = 0; BTNRi = 0; BTNLi = 0; BTNFi = 0; BTNTi = 0;
      repeat (8) @(negedge clock);
   endtask

   initial begin
      // Reset held with buttons idle
      repeat (500) @(negedge clock);
      chk("rst_AD", AD, 1); chk("rst_CS", CS, 1); chk("rst_RD", RD, 1); chk("rst_WR", WR, 1);
      chk("rst_ws", write_strobe, 0); chk("rst_kws", k_write_strobe, 0);
      chk("rst_out_port", out_port, 0); chk("rst_port_id", port_id, 0);
      for (int i = 0; i < 17; i++) chk($sformatf("rst_reg%0d", i), regs[i], 8'h00);
      reset = 1'b1;

      // Automatic read sweep
      for (int t = 0; t < 9; t++) begin
         n = 0;
         while (CS !== 1'b0 && n < 2*RDP) begin @(negedge clock); n++; end
         chk($sformatf("sweep%0d_cs_timeout", t), n < 2*RDP, 1);
         chk($sformatf("sweep%0d_addr", t), regs[9], sweep_addr[t]);
         chk($sformatf("sweep%0d_rin", t), regs[12], 8'h01);
         cs_len = 0; rd_len = 0; wr_len = 0;
         while (CS === 1'b0 && cs_len < 100) begin
            cs_len++;
            if (RD === 1'b0) rd_len++;
            if (WR === 1'b0) wr_len++;
            @(negedge clock);
         end
         chk($sformatf("sweep%0d_cs_len", t), cs_len, 2*TPH+3);
         chk($sformatf("sweep%0d_rd_len", t), rd_len, TPH);
         chk($sformatf("sweep%0d_wr_len", t), wr_len, TPH);
         repeat (3) @(negedge clock);
         chk($sformatf("sweep%0d_doner", t), regs[16], 8'h01);
      end

      // U is ignored outside programming mode
      press(1);
      chk("normal_U_ignored", regs[0], 8'h00);

      // Enter programming mode, edit rmin with wrap
      press(0);
      chk("prog_on", regs[14], 8'h01);
      repeat (4) press(3);
      repeat (59) press(1);
      chk("rmin_59", regs[4], 8'h59);
      press(1);
      chk("rmin_wrap", regs[4], 8'h00);

      // mes: 00 -D-> 12 -U-> 01 -D-> 12
      repeat (3) press(4);
      press(2);
      chk("mes_dec_from0", regs[1], 8'h12);
      press(1);
      chk("mes_inc_wrap", regs[1], 8'h01);
      press(2);
      chk("mes_dec_wrap", regs[1], 8'h12);

      // anno +2, L wraps to tseg, decrement wraps to 59, R wraps to anno
      press(4);
      press(1); press(1);
      chk("anno_02", regs[0], 8'h02);
      press(4);
      press(2);
      chk("tseg_dec_wrap", regs[8], 8'h59);
      press(3);
      press(1);
      chk("anno_03", regs[0], 8'h03);

      // Commit: 10 write transactions
      @(negedge clock); BTNFi = 1'b1;
      repeat (2) @(negedge clock); BTNFi = 1'b0;
      for (int t = 0; t < 10; t++) begin
         n = 0;
         while (CS !== 1'b0 && n < 200) begin @(negedge clock); n++; end
         chk($sformatf("cmt%0d_cs_timeout", t), n < 200, 1);
         chk($sformatf("cmt%0d_addr", t), regs[9], cmt_addr[t]);
         chk($sformatf("cmt%0d_data", t), regs[10], cmt_data[t]);
         chk($sformatf("cmt%0d_win", t), regs[11], 8'h01);
         cs_len = 0; rd_len = 0; wr_len = 0;
         while (CS === 1'b0 && cs_len < 100) begin
            cs_len++;
            if (RD === 1'b0) rd_len++;
            if (WR === 1'b0) wr_len++;
            @(negedge clock);
         end
         chk($sformatf("cmt%0d_cs_len", t), cs_len, 2*TPH+3);
         chk($sformatf("cmt%0d_wr_len", t), wr_len, 2*TPH);
         chk($sformatf("cmt%0d_rd_len", t), rd_len, 0);
         repeat (3) @(negedge clock);
         chk($sformatf("cmt%0d_donew", t), regs[15], 8'h01);
      end
      repeat (2) @(negedge clock);
      chk("cmt_prog_off", regs[14], 8'h00);

      // Timer toggle: control write with k_write_strobe, then RTC write to 0x00
      @(negedge clock); BTNTi = 1'b1;
      n = 0;
      while (write_strobe !== 1'b1 && n < 10) begin @(negedge clock); n++; end
      chk("tmr_ws_timeout", n < 10, 1);
      chk("tmr_port_id", port_id, 8'h0E);
      chk("tmr_out_port", out_port, 8'h01);
      chk("tmr_kws", k_write_strobe, 1);
      @(negedge clock);
      BTNTi = 1'b0;
      chk("tmr_control", regs[13], 8'h01);
      chk("tmr_kws_next", k_write_strobe, 0);
      n = 0;
      while (CS !== 1'b0 && n < 50) begin @(negedge clock); n++; end
      chk("tmr_cs_timeout", n < 50, 1);
      chk("tmr_addr", regs[9], 8'h00);
      chk("tmr_data", regs[10], 8'h01);
      n = 0;
      while (!(AD === 1'b1 && WR === 1'b0) && n < 50) begin @(negedge clock); n++; end
      chk("tmr_dphase_timeout", n < 50, 1);

      // Asynchronous reset in the data phase
      reset = 1'b0;
      #1;
      chk("mid_rst_WR", WR, 1); chk("mid_rst_CS", CS, 1); chk("mid_rst_AD", AD, 1);
      chk("mid_rst_RD", RD, 1); chk("mid_rst_ws", write_strobe, 0);
      chk("mid_rst_control", regs[13], 8'h00); chk("mid_rst_win", regs[11], 8'h00);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      cs_len = 0; ws_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (CS === 1'b0) cs_len++;
         if (write_strobe === 1'b1) ws_cnt++;
      end
      chk("post_rst_no_bus", cs_len, 0);
      chk("post_rst_no_writes", ws_cnt, 0);
      chk("post_rst_anno", regs[0], 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
